// File: rtl/func_prober.sv
// Probes a 2-input logical unit by stepping {a,b} through 00,01,10,11, holding each
// pattern SETTLE cycles, and recovering its 4-bit truth table (func code).
module func_prober #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [3:0] expect_i,
    input  logic       out_i,
    output logic       a_o,
    output logic       b_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] func_found_o,
    output logic       match_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] exp_q, exp_d;
    logic [3:0] found_q, found_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       match_q, match_d;
    logic       sample_s;

    assign sample_s = (cnt_q == SETTLE_LAST);

    // Next-state and output decode for the IDLE/PROBE sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        exp_d    = exp_q;
        found_d  = found_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        match_d  = match_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = PROBE;
                    exp_d    = expect_i;
                    busy_d   = 1'b1;
                    idx_d    = 2'd0;
                    cnt_d    = 4'd0;
                    shadow_d = 4'd0;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            PROBE: begin
                if (sample_s) begin
                    // The final sample is folded straight into the published result.
                    shadow_d[idx_q] = out_i;
                    cnt_d           = 4'd0;
                    if (idx_q == 2'd3) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = 2'd0;
                        found_d = shadow_d;
                        match_d = (shadow_d == exp_q);
                    end else begin
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = 2'd0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 4'd0;
            exp_q    <= 4'd0;
            found_q  <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            exp_q    <= exp_d;
            found_q  <= found_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            match_q  <= match_d;
        end
    end

    assign a_o          = idx_q[1];
    assign b_o          = idx_q[0];
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign func_found_o = found_q;
    assign match_o      = match_q;

endmodule

// File: tb/tb_func_prober.sv
// Directed bench for func_prober: SETTLE=2 and SETTLE=1 instances, each probing
// a behavioural logical unit whose output is func[{a,b}].
module tb_func_prober;

    logic       clk;
    logic       rst_n;
    logic       start2, start1;
    logic [3:0] exp2, exp1;
    logic [3:0] func2, func1;
    logic       out2, out1;
    logic       a2, b2, busy2, done2, match2;
    logic       a1, b1, busy1, done1, match1;
    logic [3:0] found2, found1;
    int         n_vec;
    int         n_err;
    int         dcnt;

    func_prober #(.SETTLE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .expect_i(exp2), .out_i(out2),
        .a_o(a2), .b_o(b2), .busy_o(busy2), .done_o(done2),
        .func_found_o(found2), .match_o(match2)
    );

    func_prober #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .expect_i(exp1), .out_i(out1),
        .a_o(a1), .b_o(b1), .busy_o(busy1), .done_o(done1),
        .func_found_o(found1), .match_o(match1)
    );

    assign out2 = func2[{a2, b2}];
    assign out1 = func1[{a1, b1}];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One full SETTLE=2 run: 8 busy cycles stepping {a,b}, then the done cycle.
    task automatic run2(input logic [3:0] f, input logic [3:0] e, input logic [3:0] prev,
                        input logic [3:0] want_found, input logic want_match);
        func2 = f;
        @(negedge clk);
        start2 = 1'b1;
        exp2   = e;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            chk("run_ab",    {2'b00, a2, b2}, 4'(k / 2));
            chk("run_busy",  {3'b000, busy2}, 4'd1);
            chk("run_done",  {3'b000, done2}, 4'd0);
            chk("run_hold",  found2, prev);
        end
        @(negedge clk);
        chk("end_busy",  {3'b000, busy2}, 4'd0);
        chk("end_done",  {3'b000, done2}, 4'd1);
        chk("end_ab",    {2'b00, a2, b2}, 4'd0);
        chk("end_found", found2, want_found);
        chk("end_match", {3'b000, match2}, {3'b000, want_match});
        @(negedge clk);
        chk("post_done", {3'b000, done2}, 4'd0);
        chk("post_found", found2, want_found);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
        exp2   = 4'd0;
        exp1   = 4'd0;
        func2  = 4'd0;
        func1  = 4'd0;
        #1;
        chk("rst_busy",  {3'b000, busy2}, 4'd0);
        chk("rst_found", found2, 4'd0);
        chk("rst_match", {3'b000, match2}, 4'd0);
        chk("rst_ab",    {2'b00, a2, b2}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic run and a mismatching run.
        run2(4'b0110, 4'b0110, 4'b0000, 4'b0110, 1'b1);
        run2(4'b1000, 4'b1110, 4'b0110, 4'b1000, 1'b0);

        // Start re-pulsed mid-run with a different expect must be ignored.
        func2 = 4'b1011;
        dcnt  = 0;
        @(negedge clk);
        start2 = 1'b1;
        exp2   = 4'b1011;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start2 = (k == 3);
            if (k >= 3) exp2 = 4'b0000;
            chk("rep_busy", {3'b000, busy2}, 4'd1);
            dcnt += int'(done2);
        end
        @(negedge clk);
        dcnt += int'(done2);
        chk("rep_done",  {3'b000, done2}, 4'd1);
        chk("rep_found", found2, 4'b1011);
        chk("rep_match", {3'b000, match2}, 4'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dcnt += int'(done2);
            chk("rep_idle", {3'b000, busy2}, 4'd0);
        end
        chk("rep_dcnt", 4'(dcnt), 4'd1);

        // Start held high: back-to-back runs with one done cycle between them.
        func2 = 4'b1011;
        @(negedge clk);
        start2 = 1'b1;
        exp2   = 4'b1011;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                chk("b2b_busy", {3'b000, busy2}, 4'd1);
                chk("b2b_ab",   {2'b00, a2, b2}, 4'(k / 2));
            end
            @(negedge clk);
            chk("b2b_gap",   {3'b000, busy2}, 4'd0);
            chk("b2b_done",  {3'b000, done2}, 4'd1);
            chk("b2b_found", found2, 4'b1011);
        end
        start2 = 1'b0;
        @(negedge clk);
        chk("b2b_stop", {3'b000, busy2}, 4'd0);

        // Asynchronous reset in cycle 5 of a run.
        func2 = 4'b0110;
        @(negedge clk);
        start2 = 1'b1;
        exp2   = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start2 = 1'b0;
        end
        chk("pre_rst_busy", {3'b000, busy2}, 4'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ab",    {2'b00, a2, b2}, 4'd0);
        chk("arst_busy",  {3'b000, busy2}, 4'd0);
        chk("arst_done",  {3'b000, done2}, 4'd0);
        chk("arst_found", found2, 4'd0);
        chk("arst_match", {3'b000, match2}, 4'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_nodone", {3'b000, done2}, 4'd0);
        end
        rst_n = 1'b1;
        run2(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);

        // SETTLE=1 instance: four busy cycles, one per pattern.
        func1 = 4'b1111;
        @(negedge clk);
        start1 = 1'b1;
        exp1   = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk("s1_ab",   {2'b00, a1, b1}, 4'(k));
            chk("s1_busy", {3'b000, busy1}, 4'd1);
        end
        @(negedge clk);
        chk("s1_done",  {3'b000, done1}, 4'd1);
        chk("s1_busy0", {3'b000, busy1}, 4'd0);
        chk("s1_found", found1, 4'b1111);
        chk("s1_match", {3'b000, match1}, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
